// File: rtl/datapath.sv
// Single-bus 32-bit datapath for the mini-RISC CPU: register file, bus source mux,
// IncPC/ROR ALU and the 64-bit Z result register, all steered by external strobes.
module datapath #(
   parameter int WIDTH      = 32,
   parameter int CSIGN_BITS = 19
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [WIDTH-1:0]   MDatain,
   input  logic [WIDTH-1:0]   InPortData,
   input  logic               PCout,
   input  logic               Zlowout,
   input  logic               Zhighout,
   input  logic               MDRout,
   input  logic               R2out,
   input  logic               R3out,
   input  logic               LOout,
   input  logic               HIout,
   input  logic               InPortout,
   input  logic               Cout,
   input  logic               PCin,
   input  logic               IRin,
   input  logic               MARin,
   input  logic               MDRin,
   input  logic               Yin,
   input  logic               Zin,
   input  logic               R1in,
   input  logic               R2in,
   input  logic               R3in,
   input  logic               HIin,
   input  logic               LOin,
   input  logic               Read,
   input  logic               IncPC,
   input  logic               ROR,
   output logic [WIDTH-1:0]   BusMuxOut,
   output logic [WIDTH-1:0]   R1_q,
   output logic [WIDTH-1:0]   R2_q,
   output logic [WIDTH-1:0]   R3_q,
   output logic [WIDTH-1:0]   PC_q,
   output logic [WIDTH-1:0]   IR_q,
   output logic [WIDTH-1:0]   MAR_q,
   output logic [WIDTH-1:0]   MDR_q,
   output logic [WIDTH-1:0]   Y_q,
   output logic [2*WIDTH-1:0] Z_q
);

   localparam int SH_W = $clog2(WIDTH);

   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic [WIDTH-1:0]   inport_q;
   logic [WIDTH-1:0]   c_ext;
   logic [WIDTH-1:0]   ror_res;
   logic [SH_W-1:0]    shamt;
   logic [2*WIDTH-1:0] alu_res;

   assign c_ext = {{(WIDTH-CSIGN_BITS){IR_q[CSIGN_BITS-1]}}, IR_q[CSIGN_BITS-1:0]};

   // NOTE: if/else chain with a default first gives the priority order and cannot infer a latch.
   always_comb begin
      BusMuxOut = '0;
      if      (MDRout)    BusMuxOut = MDR_q;
      else if (PCout)     BusMuxOut = PC_q;
      else if (Zlowout)   BusMuxOut = Z_q[WIDTH-1:0];
      else if (Zhighout)  BusMuxOut = Z_q[2*WIDTH-1:WIDTH];
      else if (R2out)     BusMuxOut = R2_q;
      else if (R3out)     BusMuxOut = R3_q;
      else if (HIout)     BusMuxOut = hi_q;
      else if (LOout)     BusMuxOut = lo_q;
      else if (InPortout) BusMuxOut = inport_q;
      else if (Cout)      BusMuxOut = c_ext;
   end

   // Rotating a doubled copy of Y right and keeping the low half is a barrel rotate.
   assign shamt   = BusMuxOut[SH_W-1:0];
   assign ror_res = WIDTH'({Y_q, Y_q} >> shamt);

   always_comb begin
      alu_res = {{WIDTH{1'b0}}, BusMuxOut};
      if (IncPC)    alu_res = {{WIDTH{1'b0}}, BusMuxOut + WIDTH'(1)};
      else if (ROR) alu_res = {{WIDTH{1'b0}}, ror_res};
   end

   // NOTE: non-blocking assignments let every register sample the pre-edge bus value.
   always_ff @(posedge clk) begin
      if (clr) begin
         R1_q     <= '0;
         R2_q     <= '0;
         R3_q     <= '0;
         PC_q     <= '0;
         IR_q     <= '0;
         MAR_q    <= '0;
         MDR_q    <= '0;
         Y_q      <= '0;
         Z_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         inport_q <= '0;
      end else begin
         if (R1in)  R1_q  <= BusMuxOut;
         if (R2in)  R2_q  <= BusMuxOut;
         if (R3in)  R3_q  <= BusMuxOut;
         if (PCin)  PC_q  <= BusMuxOut;
         if (IRin)  IR_q  <= BusMuxOut;
         if (MARin) MAR_q <= BusMuxOut;
         if (Yin)   Y_q   <= BusMuxOut;
         if (HIin)  hi_q  <= BusMuxOut;
         if (LOin)  lo_q  <= BusMuxOut;
         if (MDRin) MDR_q <= Read ? MDatain : BusMuxOut;
         if (Zin)   Z_q   <= alu_res;
         inport_q <= InPortData;
      end
   end

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: a table of one-cycle register transfers, each queuing its expected
// observations on a scoreboard that is drained before and after the clock edge.
module tb_datapath;

   localparam int NC = 25;

   localparam logic [NC-1:0] C_MDROUT    = 25'd1 << 0;
   localparam logic [NC-1:0] C_PCOUT     = 25'd1 << 1;
   localparam logic [NC-1:0] C_ZLOWOUT   = 25'd1 << 2;
   localparam logic [NC-1:0] C_ZHIGHOUT  = 25'd1 << 3;
   localparam logic [NC-1:0] C_R2OUT     = 25'd1 << 4;
   localparam logic [NC-1:0] C_R3OUT     = 25'd1 << 5;
   localparam logic [NC-1:0] C_HIOUT     = 25'd1 << 6;
   localparam logic [NC-1:0] C_LOOUT     = 25'd1 << 7;
   localparam logic [NC-1:0] C_INPORTOUT = 25'd1 << 8;
   localparam logic [NC-1:0] C_COUT      = 25'd1 << 9;
   localparam logic [NC-1:0] C_PCIN      = 25'd1 << 10;
   localparam logic [NC-1:0] C_IRIN      = 25'd1 << 11;
   localparam logic [NC-1:0] C_MARIN     = 25'd1 << 12;
   localparam logic [NC-1:0] C_MDRIN     = 25'd1 << 13;
   localparam logic [NC-1:0] C_YIN       = 25'd1 << 14;
   localparam logic [NC-1:0] C_ZIN       = 25'd1 << 15;
   localparam logic [NC-1:0] C_R1IN      = 25'd1 << 16;
   localparam logic [NC-1:0] C_R2IN      = 25'd1 << 17;
   localparam logic [NC-1:0] C_R3IN      = 25'd1 << 18;
   localparam logic [NC-1:0] C_HIIN      = 25'd1 << 19;
   localparam logic [NC-1:0] C_LOIN      = 25'd1 << 20;
   localparam logic [NC-1:0] C_READ      = 25'd1 << 21;
   localparam logic [NC-1:0] C_INCPC     = 25'd1 << 22;
   localparam logic [NC-1:0] C_ROR       = 25'd1 << 23;
   localparam logic [NC-1:0] C_CLR       = 25'd1 << 24;

   typedef enum int {O_NONE, O_BUS, O_R1, O_R2, O_R3, O_PC, O_IR, O_MAR, O_MDR, O_Y, O_ZLO, O_ZHI} obs_t;

   typedef struct {
      string       name;
      logic [NC-1:0] ctrl;
      logic [31:0] md;
      obs_t        o1;
      logic [31:0] e1;
      obs_t        o2;
      logic [31:0] e2;
   } vec_t;

   typedef struct {
      string       name;
      obs_t        obs;
      logic [31:0] val;
   } exp_t;

   logic          clk = 1'b0;
   logic [NC-1:0] ctrl = C_CLR;
   logic [31:0]   mdatain = '0;
   logic [31:0]   inport_data = 32'hCAFE0001;
   logic [31:0]   bus, r1, r2, r3, pc, ir, mar, mdr, y;
   logic [63:0]   z;

   int n_tests = 0;
   int n_fail  = 0;
   vec_t vecs[$];
   exp_t sb[$];

   always #5 clk = ~clk;

   datapath dut (
      .clk(clk), .clr(ctrl[24]), .MDatain(mdatain), .InPortData(inport_data),
      .MDRout(ctrl[0]), .PCout(ctrl[1]), .Zlowout(ctrl[2]), .Zhighout(ctrl[3]),
      .R2out(ctrl[4]), .R3out(ctrl[5]), .HIout(ctrl[6]), .LOout(ctrl[7]),
      .InPortout(ctrl[8]), .Cout(ctrl[9]),
      .PCin(ctrl[10]), .IRin(ctrl[11]), .MARin(ctrl[12]), .MDRin(ctrl[13]),
      .Yin(ctrl[14]), .Zin(ctrl[15]), .R1in(ctrl[16]), .R2in(ctrl[17]),
      .R3in(ctrl[18]), .HIin(ctrl[19]), .LOin(ctrl[20]),
      .Read(ctrl[21]), .IncPC(ctrl[22]), .ROR(ctrl[23]),
      .BusMuxOut(bus), .R1_q(r1), .R2_q(r2), .R3_q(r3), .PC_q(pc), .IR_q(ir),
      .MAR_q(mar), .MDR_q(mdr), .Y_q(y), .Z_q(z)
   );

   function automatic logic [31:0] read_out(obs_t o);
      case (o)
         O_BUS:   return bus;
         O_R1:    return r1;
         O_R2:    return r2;
         O_R3:    return r3;
         O_PC:    return pc;
         O_IR:    return ir;
         O_MAR:   return mar;
         O_MDR:   return mdr;
         O_Y:     return y;
         O_ZLO:   return z[31:0];
         O_ZHI:   return z[63:32];
         default: return 32'hDEADBEEF;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(string n, logic [NC-1:0] c, logic [31:0] md,
                               obs_t o1, logic [31:0] e1, obs_t o2, logic [31:0] e2);
      vec_t v;
      v.name = n; v.ctrl = c; v.md = md; v.o1 = o1; v.e1 = e1; v.o2 = o2; v.e2 = e2;
      return v;
   endfunction

   // Bus observations come first in the queue and are compared mid-cycle; the rest after the edge.
   task automatic run_step(input vec_t v);
      exp_t e;
      ctrl    = v.ctrl;
      mdatain = v.md;
      if (v.o1 == O_BUS) sb.push_back('{v.name, v.o1, v.e1});
      if (v.o2 == O_BUS) sb.push_back('{{v.name, "_2"}, v.o2, v.e2});
      if (v.o1 != O_BUS && v.o1 != O_NONE) sb.push_back('{v.name, v.o1, v.e1});
      if (v.o2 != O_BUS && v.o2 != O_NONE) sb.push_back('{{v.name, "_2"}, v.o2, v.e2});
      #2;
      while (sb.size() > 0 && sb[0].obs == O_BUS) begin
         e = sb.pop_front();
         check(e.name, read_out(e.obs), e.val);
      end
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.name, read_out(e.obs), e.val);
      end
      ctrl = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit %0d ns", 200000);
      $fatal(1);
   end

   initial begin
      @(posedge clk);
      #1;
      ctrl = '0;

      // Dirty several registers, then reset with loads asserted to prove clr wins.
      run_step(mk("pre_mdr", C_READ | C_MDRIN, 32'hFFFFFFFF, O_MDR, 32'hFFFFFFFF, O_NONE, 0));
      run_step(mk("pre_r1", C_MDROUT | C_R1IN | C_PCIN, 0, O_R1, 32'hFFFFFFFF, O_PC, 32'hFFFFFFFF));
      run_step(mk("pre_z", C_MDROUT | C_ZIN | C_YIN, 0, O_ZLO, 32'hFFFFFFFF, O_Y, 32'hFFFFFFFF));
      ctrl = C_CLR | C_MDROUT | C_R1IN | C_ZIN | C_YIN;
      @(posedge clk);
      #1;
      ctrl = '0;
      #1;
      check("rst_r1", r1, 0);   check("rst_r2", r2, 0);   check("rst_r3", r3, 0);
      check("rst_pc", pc, 0);   check("rst_ir", ir, 0);   check("rst_mar", mar, 0);
      check("rst_mdr", mdr, 0); check("rst_y", y, 0);
      check("rst_zlo", z[31:0], 0); check("rst_zhi", z[63:32], 0);
      check("rst_bus_idle", bus, 0);

      vecs.push_back(mk("mdr_12",   C_READ | C_MDRIN, 32'h12, O_MDR, 32'h12, O_NONE, 0));
      vecs.push_back(mk("r2_12",    C_MDROUT | C_R2IN, 0, O_R2, 32'h12, O_NONE, 0));
      vecs.push_back(mk("mdr_14",   C_READ | C_MDRIN, 32'h14, O_MDR, 32'h14, O_NONE, 0));
      vecs.push_back(mk("r3_14",    C_MDROUT | C_R3IN, 0, O_R3, 32'h14, O_NONE, 0));
      vecs.push_back(mk("mdr_18",   C_READ | C_MDRIN, 32'h18, O_MDR, 32'h18, O_NONE, 0));
      vecs.push_back(mk("r1_18",    C_MDROUT | C_R1IN, 0, O_R1, 32'h18, O_NONE, 0));
      vecs.push_back(mk("fetch_t0", C_PCOUT | C_MARIN | C_INCPC | C_ZIN, 0, O_MAR, 0, O_ZLO, 32'h1));
      vecs.push_back(mk("fetch_t1", C_ZLOWOUT | C_PCIN | C_READ | C_MDRIN, 32'h28918000,
                        O_PC, 32'h1, O_MDR, 32'h28918000));
      vecs.push_back(mk("fetch_t2", C_MDROUT | C_IRIN, 0, O_IR, 32'h28918000, O_NONE, 0));
      vecs.push_back(mk("cout_pos", C_COUT, 0, O_BUS, 32'h00018000, O_NONE, 0));
      vecs.push_back(mk("ror_y",    C_R2OUT | C_YIN, 0, O_Y, 32'h12, O_NONE, 0));
      vecs.push_back(mk("ror_z",    C_R3OUT | C_ROR | C_ZIN, 0, O_ZLO, 32'h00012000, O_ZHI, 0));
      vecs.push_back(mk("ror_r1",   C_ZLOWOUT | C_R1IN, 0, O_R1, 32'h00012000, O_NONE, 0));
      vecs.push_back(mk("ror_sh0",  C_ROR | C_ZIN, 0, O_BUS, 0, O_ZLO, 32'h12));
      vecs.push_back(mk("mdr_21",   C_READ | C_MDRIN, 32'h21, O_MDR, 32'h21, O_NONE, 0));
      vecs.push_back(mk("r3_21",    C_MDROUT | C_R3IN, 0, O_R3, 32'h21, O_NONE, 0));
      vecs.push_back(mk("mdr_1",    C_READ | C_MDRIN, 32'h1, O_MDR, 32'h1, O_NONE, 0));
      vecs.push_back(mk("y_1",      C_MDROUT | C_YIN, 0, O_Y, 32'h1, O_NONE, 0));
      vecs.push_back(mk("ror_wrap", C_R3OUT | C_ROR | C_ZIN, 0, O_ZLO, 32'h80000000, O_NONE, 0));
      vecs.push_back(mk("mdr_1f",   C_READ | C_MDRIN, 32'h1F, O_MDR, 32'h1F, O_NONE, 0));
      vecs.push_back(mk("ror_sh31", C_MDROUT | C_ROR | C_ZIN, 0, O_ZLO, 32'h2, O_NONE, 0));
      vecs.push_back(mk("inc_prio", C_MDROUT | C_INCPC | C_ROR | C_ZIN, 0, O_ZLO, 32'h20, O_NONE, 0));
      vecs.push_back(mk("mdr_ff",   C_READ | C_MDRIN, 32'hFFFFFFFF, O_MDR, 32'hFFFFFFFF, O_NONE, 0));
      vecs.push_back(mk("inc_wrap", C_MDROUT | C_INCPC | C_ZIN, 0, O_ZLO, 0, O_ZHI, 0));
      vecs.push_back(mk("prio_mdr_pc", C_MDROUT | C_PCOUT, 0, O_BUS, 32'hFFFFFFFF, O_NONE, 0));
      vecs.push_back(mk("prio_pc_z", C_PCOUT | C_ZLOWOUT, 0, O_BUS, 32'h1, O_NONE, 0));
      vecs.push_back(mk("mdr_1234", C_READ | C_MDRIN, 32'h12345678, O_MDR, 32'h12345678, O_NONE, 0));
      vecs.push_back(mk("ir_lo",    C_MDROUT | C_IRIN | C_LOIN, 0, O_IR, 32'h12345678, O_NONE, 0));
      vecs.push_back(mk("cout_neg", C_COUT, 0, O_BUS, 32'hFFFC5678, O_NONE, 0));
      vecs.push_back(mk("inport_hi", C_INPORTOUT | C_HIIN, 0, O_BUS, 32'hCAFE0001, O_NONE, 0));
      vecs.push_back(mk("prio_hi_lo", C_HIOUT | C_LOOUT, 0, O_BUS, 32'hCAFE0001, O_NONE, 0));
      vecs.push_back(mk("lo_to_y",  C_LOOUT | C_YIN, 0, O_Y, 32'h12345678, O_NONE, 0));
      vecs.push_back(mk("prio_zhi_r2", C_ZHIGHOUT | C_R2OUT, 0, O_BUS, 0, O_NONE, 0));
      vecs.push_back(mk("rw_same_mdr", C_MDROUT | C_READ | C_MDRIN, 32'h55,
                        O_BUS, 32'h12345678, O_MDR, 32'h55));
      vecs.push_back(mk("prio_r2_in", C_R2OUT | C_INPORTOUT, 0, O_BUS, 32'h12, O_NONE, 0));
      vecs.push_back(mk("idle_hold", '0, 0, O_BUS, 0, O_R3, 32'h21));

      foreach (vecs[i]) run_step(vecs[i]);

      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
